altr_hps_rst_seq: RTL
=====================

Name: altr_hps_rst_seq

Overview:
- Reset-release sequencer for NUM_DOM downstream reset domains. Each domain output feeds a per-domain synchroniser/rstnsync stage.
- After system reset, domains are released one at a time in ascending index order, with a programmable gap between releases.
- A software/HPS warm-reset request re-asserts the domains in descending order and acknowledges with a 4-phase handshake.
- A scan bypass forces every domain output to follow the block reset input.

Parameters:
- NUM_DOM, 4: number of reset domains; legal range 1..16.
- CNT_W, 8: width of the gap counter and of dly_cfg.

Ports:
- clk  input  1  block clock.
- rst_n  input  1  block reset, synchronous, active-low.
- scan_mode  input  1  1 = scan bypass; every dom_rst_n bit follows rst_n combinationally.
- dly_cfg  input  CNT_W  gap between consecutive domain releases; the gap is dly_cfg+1 cycles.
- rst_req  input  1  warm-reset request, level, 4-phase.
- rst_ack  output  1  warm-reset acknowledge.
- dom_rst_n  output  NUM_DOM  per-domain reset, active-low; bit 0 is released first.
- seq_done  output  1  1 = all domains released and the block is idle.

Behaviour:
- Reset (rst_n=0 sampled at a clk edge):
  - state=REL, dom_rst_n=0, rst_ack=0, seq_done=0, idx=0.
  - cnt is loaded from dly_cfg and held while rst_n=0.
- FSM states: REL, ACTIVE, ASSERT, HOLD. All outputs are registered except the scan mux.
- REL:
  - cnt decrements each cycle. When cnt==0: set dom_rst_n[idx]=1, reload cnt from dly_cfg, idx++.
  - When the released idx is NUM_DOM-1, go to ACTIVE.
  - Timing: domain k deasserts (k+1)*(dly_cfg+1) cycles after the first clk edge with rst_n=1.
  - dly_cfg is sampled only at each reload. Changes mid-gap do not affect the gap in progress.
- ACTIVE:
  - seq_done=1 (registered, same edge as the last domain release).
  - rst_req=1 -> go to ASSERT, seq_done=0 on that edge.
- ASSERT:
  - One domain is cleared per cycle in descending order, starting at the highest released index.
  - After dom_rst_n[0] clears, go to HOLD. rst_ack=1 on the edge after dom_rst_n reaches all-zero.
- HOLD:
  - dom_rst_n=0, rst_ack=1.
  - On rst_req=0: rst_ack=0, idx=0, cnt reloaded from dly_cfg, go to REL. The release sequence repeats with identical timing.
- rst_req during REL (abort):
  - Go to ASSERT on the next edge. Only already-released domains are cleared, highest first.
  - If no domain has been released yet, go directly to HOLD.
- rst_req deasserted during ASSERT: ignored. ASSERT completes, then HOLD is entered. HOLD exits on the next cycle because rst_req=0; rst_ack pulses exactly 1 cycle.
- rst_n=0 in any state: immediate return to reset values at that edge. This overrides rst_req.
- scan_mode=1:
  - dom_rst_n = {NUM_DOM{rst_n}}.
  - FSM, rst_ack and seq_done keep running unchanged.
  - Deasserting scan_mode mid-sequence exposes the registered values with no glitch filtering.
- Invariant: dom_rst_n is always thermometer-coded, i.e. of the form 0..01..1. A higher domain is never released while a lower one is in reset.
- dly_cfg=0: one domain per cycle. Maximum gap: 2^CNT_W cycles.

Test Plan:
- Power-on release, NUM_DOM=4, dly_cfg=3: deassert rst_n at edge 0 -> dom_rst_n goes 0001 at cycle 4, 0011 at 8, 0111 at 12, 1111 at 16; seq_done=1 at 16.
- Warm reset from ACTIVE, dly_cfg=0: raise rst_req -> dom_rst_n goes 0111, 0011, 0001, 0000 on consecutive cycles; rst_ack=1 the cycle after 0000. Drop rst_req -> rst_ack=0; dom_rst_n is 0001..1111 at 1-cycle gaps afterwards.
- Abort mid-release, dly_cfg=5: assert rst_req when dom_rst_n=0011 -> next cycles 0001 then 0000, then rst_ack=1. Bits 2 and 3 are never set.
- Request before any release: rst_req=1 within the first dly_cfg cycles after rst_n rises -> dom_rst_n stays 0000, rst_ack=1 after one cycle, seq_done stays 0.
- Sync reset mid-sequence: drive rst_n=0 with dom_rst_n=0111 and rst_ack=0 -> all outputs 0 after that edge. Changing dly_cfg from 3 to 7 mid-gap affects only the next gap.
- Scan bypass: scan_mode=1, toggle rst_n -> dom_rst_n=1111/0000 with zero latency regardless of state. Release scan_mode -> registered thermometer value reappears.

Source files
------------

// File: rtl/altr_hps_rst_seq.sv
// ---------------------------------------------------------------------------
// altr_hps_rst_seq
//
// Reset-release sequencer for NUM_DOM downstream reset domains.
//   * After block reset the domains are released one at a time, lowest index
//     first, with a gap of dly_cfg+1 cycles between releases.
//   * A warm-reset request (rst_req) puts the released domains back into
//     reset, highest index first, one per cycle. The request is then
//     acknowledged on rst_ack with a 4-phase handshake.
//   * scan_mode bypasses the sequencer so that every domain reset follows
//     rst_n combinationally.
//
// Ports
//   clk        block clock
//   rst_n      block reset, synchronous, active-low
//   scan_mode  1 = every dom_rst_n bit follows rst_n
//   dly_cfg    release gap minus one, sampled at each counter reload
//   rst_req    warm-reset request (level, 4-phase)
//   rst_ack    warm-reset acknowledge
//   dom_rst_n  per-domain reset, active-low; bit 0 is released first
//   seq_done   all domains released and the block is idle
// ---------------------------------------------------------------------------
module altr_hps_rst_seq #(
    parameter int NUM_DOM = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               scan_mode,
    input  logic [CNT_W-1:0]   dly_cfg,
    input  logic               rst_req,
    output logic               rst_ack,
    output logic [NUM_DOM-1:0] dom_rst_n,
    output logic               seq_done
);

    localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOM - 1);

    typedef enum logic [1:0] {
        S_REL    = 2'd0,   // releasing domains in ascending order
        S_ACTIVE = 2'd1,   // all domains released, idle
        S_ASSERT = 2'd2,   // re-asserting domains in descending order
        S_HOLD   = 2'd3    // all domains in reset, acknowledging request
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [NUM_DOM-1:0] dom_q,   dom_d;
    logic               ack_q,   ack_d;
    logic               done_q,  done_d;

    // dom_q is kept thermometer-coded: releasing shifts a one in at the
    // bottom, re-asserting shifts the top one out. That way a higher domain
    // can never be out of reset while a lower one is still held.
    always_comb begin
        // NOTE: every variable gets its hold value first so that paths which
        // do not assign it cannot infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dom_d   = dom_q;
        ack_d   = ack_q;
        done_d  = done_q;

        case (state_q)
            S_REL: begin
                if (rst_req) begin
                    // Abort: only domains already released need clearing.
                    if (dom_q == '0) begin
                        state_d = S_HOLD;
                        ack_d   = 1'b1;
                    end else begin
                        dom_d   = dom_q >> 1;
                        state_d = S_ASSERT;
                    end
                end else if (cnt_q == '0) begin
                    dom_d = (dom_q << 1) | NUM_DOM'(1);
                    cnt_d = dly_cfg;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_ACTIVE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_ACTIVE: begin
                if (rst_req) begin
                    dom_d   = dom_q >> 1;
                    done_d  = 1'b0;
                    state_d = S_ASSERT;
                end
            end

            S_ASSERT: begin
                // The acknowledge comes one edge after the last domain clears,
                // so downstream logic sees all-zero for a full cycle first.
                // A withdrawn request is ignored here; HOLD handles it.
                if (dom_q == '0) begin
                    state_d = S_HOLD;
                    ack_d   = 1'b1;
                end else begin
                    dom_d = dom_q >> 1;
                end
            end

            S_HOLD: begin
                if (!rst_req) begin
                    ack_d   = 1'b0;
                    idx_d   = '0;
                    cnt_d   = dly_cfg;
                    state_d = S_REL;
                end
            end

            default: state_d = S_REL;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_n) begin
            state_q <= S_REL;
            cnt_q   <= dly_cfg;   // keeps tracking dly_cfg while held in reset
            idx_q   <= '0;
            dom_q   <= '0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dom_q   <= dom_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
        end
    end

    // Scan bypass is the only combinational path to an output.
    assign dom_rst_n = scan_mode ? {NUM_DOM{rst_n}} : dom_q;
    assign rst_ack   = ack_q;
    assign seq_done  = done_q;

endmodule
